dadda4x4_3_2: RTL and testbench

DADDA4X4_3_2 -- requirements
Module: dadda4x4_3_2

---
 rtl/dadda4x4_3_2_pkg.sv | 6 +
 rtl/dadda4x4_3_2_fa.sv | 11 +
 rtl/dadda4x4_3_2.sv | 84 ++++++++
 tb/tb_dadda4x4_3_2.sv | 113 +++++++++++
 4 files changed

// File: rtl/dadda4x4_3_2_pkg.sv
// Shared width constants for the 4x4 Dadda multiplier.
package dadda4x4_3_2_pkg;
    localparam int A_W   = 4;
    localparam int P_W   = 8;
    localparam int COL_N = P_W - 1;  // partial-product columns 0..6
endpackage

// File: rtl/dadda4x4_3_2_fa.sv
// 3:2 counter used both in the Dadda tree and in the final ripple adder.
module full_adder_3_2 (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic sum,
    output logic cout
);
    assign sum  = x ^ y ^ z;
    assign cout = (x & y) | (x & z) | (y & z);
endmodule

// File: rtl/dadda4x4_3_2.sv
// Unsigned 4x4 Dadda multiplier (heights 4->3->2) with a registered product.
module dadda4x4_3_2
    import dadda4x4_3_2_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [A_W-1:0] a,
    input  logic [A_W-1:0] b,
    input  logic           in_valid,
    output logic [P_W-1:0] out,
    output logic           out_valid
);
    // pp[i][j] = a[i] & b[j], weight i+j
    logic [A_W-1:0][A_W-1:0] pp;

    for (genvar gi = 0; gi < A_W; gi++) begin : g_pp_row
        for (genvar gj = 0; gj < A_W; gj++) begin : g_pp_col
            assign pp[gi][gj] = a[gi] & b[gj];
        end
    end

    // Stage 1 (target 3): half adders in columns 3 and 4.
    logic s1_3, c1_4, s1_4, c1_5;
    assign s1_3 = pp[3][0] ^ pp[2][1];
    assign c1_4 = pp[3][0] & pp[2][1];
    assign s1_4 = pp[3][1] ^ pp[2][2];
    assign c1_5 = pp[3][1] & pp[2][2];

    // Stage 2 (target 2): half adder in column 2, full adders in columns 3..5.
    logic s2_2, c2_3, s2_3, c2_4, s2_4, c2_5, s2_5, c2_6;
    assign s2_2 = pp[2][0] ^ pp[1][1];
    assign c2_3 = pp[2][0] & pp[1][1];

    full_adder_3_2 u_fa_s2_c3 (.x(s1_3),     .y(pp[1][2]), .z(pp[0][3]), .sum(s2_3), .cout(c2_4));
    full_adder_3_2 u_fa_s2_c4 (.x(s1_4),     .y(pp[1][3]), .z(c1_4),     .sum(s2_4), .cout(c2_5));
    full_adder_3_2 u_fa_s2_c5 (.x(pp[3][2]), .y(pp[2][3]), .z(c1_5),     .sum(s2_5), .cout(c2_6));

    // Two remaining rows, one bit per column 0..6.
    logic [COL_N-1:0] row0, row1;
    assign row0 = {pp[3][3], s2_5, s2_4, s2_3, s2_2, pp[1][0], pp[0][0]};
    assign row1 = {c2_6, c2_5, c2_4, c2_3, pp[0][2], pp[0][1], 1'b0};

    logic [COL_N:0]   carry;
    logic [COL_N-1:0] cpa_sum;
    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < COL_N; gi++) begin : g_cpa
        full_adder_3_2 u_fa_cpa (
            .x   (row0[gi]),
            .y   (row1[gi]),
            .z   (carry[gi]),
            .sum (cpa_sum[gi]),
            .cout(carry[gi+1])
        );
    end

    logic [P_W-1:0] product;
    assign product = {carry[COL_N], cpa_sum};

    logic [P_W-1:0] out_q, out_d;
    logic           out_valid_q, out_valid_d;

    // The mux keeps a/b entirely out of the register path while in_valid is low.
    always_comb begin
        out_d       = out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d = product;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_dadda4x4_3_2.sv
// Directed and exhaustive checks of the registered 4x4 Dadda multiplier.
module tb_dadda4x4_3_2;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b;
    logic       in_valid;
    logic [7:0] out;
    logic       out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    dadda4x4_3_2 dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
        .out      (out),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Drive inputs at a falling edge, then advance to the next falling edge.
    task automatic step(input logic [3:0] ta, input logic [3:0] tb_v, input logic v, input logic r);
        a        = ta;
        b        = tb_v;
        in_valid = v;
        rst      = r;
        @(negedge clk);
    endtask

    // Directed vectors: a, b, hand-computed product
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[7] = '{
        '{4'd15, 4'd15, 8'd225},
        '{4'd0,  4'd13, 8'd0},
        '{4'd9,  4'd7,  8'd63},
        '{4'd15, 4'd1,  8'd15},
        '{4'd8,  4'd8,  8'd64},
        '{4'd12, 4'd12, 8'd144},
        '{4'd11, 4'd13, 8'd143}
    };

    initial begin
        a = 4'd3; b = 4'd3; in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        // Valid input held during reset is discarded.
        step(4'd3, 4'd3, 1'b1, 1'b1);
        check("reset_out", out, 8'd0);
        check("reset_valid", {7'd0, out_valid}, 8'd0);

        // First cycle after reset with in_valid low.
        step(4'd7, 4'd7, 1'b0, 1'b0);
        check("post_reset_valid", {7'd0, out_valid}, 8'd0);
        check("post_reset_out", out, 8'd0);

        foreach (vecs[i]) begin
            step(vecs[i].a, vecs[i].b, 1'b1, 1'b0);
            check($sformatf("vec_%0dx%0d", vecs[i].a, vecs[i].b), out, vecs[i].p);
            check("vec_valid", {7'd0, out_valid}, 8'd1);
        end

        // Hold while idle.
        step(4'd5, 4'd6, 1'b1, 1'b0);
        check("hold_load", out, 8'd30);
        step(4'd15, 4'd15, 1'b0, 1'b0);
        check("hold_out", out, 8'd30);
        check("hold_valid", {7'd0, out_valid}, 8'd0);
        step(4'd15, 4'd15, 1'b0, 1'b0);
        check("hold_out_2", out, 8'd30);

        // Reset mid-stream.
        step(4'd15, 4'd15, 1'b1, 1'b0);
        check("mid_pending", out, 8'd225);
        step(4'd7, 4'd3, 1'b1, 1'b1);
        check("mid_rst_out", out, 8'd0);
        check("mid_rst_valid", {7'd0, out_valid}, 8'd0);
        step(4'd9, 4'd7, 1'b1, 1'b0);
        check("mid_after_out", out, 8'd63);
        check("mid_after_valid", {7'd0, out_valid}, 8'd1);

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 256; i++) begin
            logic [3:0] ea, eb;
            ea = 4'(i >> 4);
            eb = 4'(i);
            step(ea, eb, 1'b1, 1'b0);
            check($sformatf("sweep_%0dx%0d", ea, eb), out, 8'(ea * eb));
            check("sweep_valid", {7'd0, out_valid}, 8'd1);
        end

        in_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
